// File: rtl/frame_fill_writer_if.sv
// Command / framebuffer-write / continuation bundle for frame_fill_writer.
// master: command source and next stage; slave: the fill writer itself.
interface frame_fill_if #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int ADDR_SIZE  = 15,
    parameter int COLOR_SIZE = 3
) ();
    logic                  in_cont_signal;
    logic [X_BITS-1:0]     cmd_x;
    logic [Y_BITS-1:0]     cmd_y;
    logic [X_BITS-1:0]     cmd_w;
    logic [Y_BITS-1:0]     cmd_h;
    logic [COLOR_SIZE-1:0] cmd_color;
    logic                  wr_en;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [COLOR_SIZE-1:0] wr_data;
    logic                  busy;
    logic                  out_cont_signal;
    logic                  next_fin_signal;

    modport master (
        output in_cont_signal, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output next_fin_signal,
        input  wr_en, wr_addr, wr_data, busy, out_cont_signal
    );

    modport slave (
        input  in_cont_signal, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  next_fin_signal,
        output wr_en, wr_addr, wr_data, busy, out_cont_signal
    );
endinterface

// File: rtl/frame_fill_writer.sv
// Rectangle fill writer: clips a fill command to the screen and writes the
// colour into every covered framebuffer word, one word per clock, raster
// order. Ports: Clck, Reset (sync, active-low), bus (frame_fill_if.slave).
module frame_fill_writer #(
    parameter int SCR_WIDTH  = 160,
    parameter int SCR_HEIGHT = 120,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int ADDR_SIZE  = 15,
    parameter int COLOR_SIZE = 3
) (
    input logic       Clck,
    input logic       Reset,
    frame_fill_if.slave bus
);
    localparam int XE = X_BITS + 1;
    localparam int YE = Y_BITS + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t state, nxt_state;

    logic [X_BITS-1:0]     lat_x, lat_w, cur_x, nxt_x;
    logic [Y_BITS-1:0]     lat_y, lat_h, cur_y, nxt_y;
    logic [COLOR_SIZE-1:0] lat_c;

    logic                  wr_en_q;
    logic [ADDR_SIZE-1:0]  wr_addr_q;
    logic [COLOR_SIZE-1:0] wr_data_q;
    logic                  busy_q;
    logic                  out_cont_q;

    logic [XE-1:0] x_sum, x_end;
    logic [YE-1:0] y_sum, y_end;
    logic          degen, x_last, y_last;
    logic          accept, fin_ack;
    logic [ADDR_SIZE-1:0] cur_addr;

    // Extra sum bit keeps origin+size from wrapping before the clip.
    assign x_sum = {1'b0, lat_x} + {1'b0, lat_w};
    assign y_sum = {1'b0, lat_y} + {1'b0, lat_h};
    assign x_end = (x_sum > XE'(SCR_WIDTH))  ? XE'(SCR_WIDTH)  : x_sum;
    assign y_end = (y_sum > YE'(SCR_HEIGHT)) ? YE'(SCR_HEIGHT) : y_sum;

    assign degen = (lat_w == '0) || (lat_h == '0)
                || ({1'b0, lat_x} >= XE'(SCR_WIDTH))
                || ({1'b0, lat_y} >= YE'(SCR_HEIGHT));

    assign x_last = ({1'b0, cur_x} + XE'(1)) == x_end;
    assign y_last = ({1'b0, cur_y} + YE'(1)) == y_end;

    assign cur_addr = ADDR_SIZE'(cur_x)
                    + ADDR_SIZE'(cur_y) * ADDR_SIZE'(SCR_WIDTH);

    // DONE is only left once the finish flag is actually visible outside.
    assign fin_ack = (state == DONE) && out_cont_q && bus.next_fin_signal;

    always_ff @(posedge Clck) begin
        if (!Reset) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        nxt_x     = cur_x;
        nxt_y     = cur_y;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_cont_signal && !out_cont_q) begin
                    accept    = 1'b1;
                    nxt_state = LOAD;
                end
            end
            LOAD: begin
                if (degen) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = WRITE;
                    nxt_x     = lat_x;
                    nxt_y     = lat_y;
                end
            end
            WRITE: begin
                if (x_last) begin
                    nxt_x = lat_x;
                    if (y_last) nxt_state = DONE;
                    else        nxt_y = cur_y + Y_BITS'(1);
                end else begin
                    nxt_x = cur_x + X_BITS'(1);
                end
            end
            DONE: begin
                if (fin_ack) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs lag the state by one register stage: a WRITE cycle becomes
    // a wr_en cycle on the following edge.
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            lat_x      <= '0;
            lat_y      <= '0;
            lat_w      <= '0;
            lat_h      <= '0;
            lat_c      <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            out_cont_q <= 1'b0;
        end else begin
            if (accept) begin
                lat_x <= bus.cmd_x;
                lat_y <= bus.cmd_y;
                lat_w <= bus.cmd_w;
                lat_h <= bus.cmd_h;
                lat_c <= bus.cmd_color;
            end
            cur_x   <= nxt_x;
            cur_y   <= nxt_y;
            wr_en_q <= (state == WRITE);
            if (state == WRITE) begin
                wr_addr_q <= cur_addr;
                wr_data_q <= lat_c;
            end
            busy_q     <= accept || (busy_q && !fin_ack);
            out_cont_q <= (state == DONE) && !fin_ack;
        end
    end

    assign bus.wr_en           = wr_en_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.busy            = busy_q;
    assign bus.out_cont_signal = out_cont_q;
endmodule

// File: tb/tb_frame_fill_writer.sv
// Directed-vector bench for frame_fill_writer.
// Each task drives one scenario and checks hand-computed expectations.
module tb_frame_fill_writer;
    logic Clck = 1'b0;
    logic Reset;

    always #5 Clck = ~Clck;

    frame_fill_if #(
        .X_BITS(8), .Y_BITS(7), .ADDR_SIZE(15), .COLOR_SIZE(3)
    ) bus ();

    frame_fill_writer #(
        .SCR_WIDTH(160), .SCR_HEIGHT(120), .X_BITS(8), .Y_BITS(7),
        .ADDR_SIZE(15), .COLOR_SIZE(3)
    ) dut (
        .Clck (Clck),
        .Reset(Reset),
        .bus  (bus)
    );

    int vecs = 0;
    int errs = 0;
    int wa[$];
    int wd[$];

    task automatic step();
        @(posedge Clck);
        #1;
    endtask

    task automatic set_cmd(input int x, input int y, input int w,
                           input int h, input int c);
        bus.cmd_x     = x[7:0];
        bus.cmd_y     = y[6:0];
        bus.cmd_w     = w[7:0];
        bus.cmd_h     = h[6:0];
        bus.cmd_color = c[2:0];
    endtask

    task automatic issue(input int x, input int y, input int w,
                         input int h, input int c);
        set_cmd(x, y, w, h, c);
        bus.in_cont_signal = 1'b1;
        step();
        bus.in_cont_signal = 1'b0;
    endtask

    task automatic ack();
        bus.next_fin_signal = 1'b1;
        step();
        bus.next_fin_signal = 1'b0;
    endtask

    // Records writes after an accept edge until out_cont rises.
    // k counts edges after the accept edge; done_k=-1 on timeout.
    task automatic collect(input int bound, input int mutate_at,
                           output int first_k, output int done_k,
                           output bit gap, output bit overlap);
        bit mutated = 1'b0;
        wa.delete();
        wd.delete();
        first_k = -1;
        done_k  = -1;
        gap     = 1'b0;
        overlap = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            step();
            if (bus.wr_en) begin
                wa.push_back(int'(bus.wr_addr));
                wd.push_back(int'(bus.wr_data));
                if (first_k < 0) first_k = k;
            end else if (first_k >= 0 && !bus.out_cont_signal) begin
                gap = 1'b1;
            end
            if (bus.wr_en && bus.out_cont_signal) overlap = 1'b1;
            if (mutate_at > 0 && !mutated && wa.size() == mutate_at) begin
                set_cmd(0, 0, 50, 50, 2);
                bus.in_cont_signal = 1'b1;
                mutated = 1'b1;
            end
            if (bus.out_cont_signal) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        set_cmd(10, 5, 3, 2, 5);
        bus.in_cont_signal = 1'b1;
        step();
        step();
        vecs++;
        if (bus.wr_en !== 1'b0) begin
            errs++;
            $display("FAIL rst_wr_en got %b want 0", bus.wr_en);
        end
        vecs++;
        if (bus.wr_addr !== 15'd0) begin
            errs++;
            $display("FAIL rst_wr_addr got %0d want 0", bus.wr_addr);
        end
        vecs++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_busy got %b want 0", bus.busy);
        end
        vecs++;
        if (bus.out_cont_signal !== 1'b0) begin
            errs++;
            $display("FAIL rst_out_cont got %b want 0",
                     bus.out_cont_signal);
        end
        bus.in_cont_signal = 1'b0;
        Reset = 1'b1;
        step();
        vecs++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            errs++;
            $display("FAIL rst_no_accept got busy=%b wr_en=%b want 0/0",
                     bus.busy, bus.wr_en);
        end
    endtask

    task automatic test_basic_fill();
        int exp_a[6] = '{810, 811, 812, 970, 971, 972};
        int fk, dk, bad;
        bit gp, ov;
        issue(10, 5, 3, 2, 5);
        vecs++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_busy got %b want 1", bus.busy);
        end
        collect(50, 0, fk, dk, gp, ov);
        vecs++;
        if (wa.size() != 6) begin
            errs++;
            $display("FAIL basic_count got %0d want 6", wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vecs++;
                if (wa[i] != exp_a[i] || wd[i] != 5) begin
                    errs++;
                    $display("FAIL basic_wr%0d got %0d/%0d want %0d/5",
                             i, wa[i], wd[i], exp_a[i]);
                end
            end
        end
        vecs++;
        if (fk != 2) begin
            errs++;
            $display("FAIL basic_first_latency got %0d want 2", fk);
        end
        vecs++;
        if (dk != 8 || gp || ov) begin
            errs++;
            $display("FAIL basic_done got k=%0d gap=%b ovl=%b want 8/0/0",
                     dk, gp, ov);
        end
        bad = 0;
        repeat (20) begin
            step();
            if (bus.out_cont_signal !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL basic_hold got %0d drops want 0", bad);
        end
        ack();
        vecs++;
        if (bus.out_cont_signal !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_ack got oc=%b busy=%b want 0/0",
                     bus.out_cont_signal, bus.busy);
        end
    endtask

    task automatic test_clipping();
        int fk, dk;
        bit gp, ov;
        issue(158, 119, 5, 4, 3);
        collect(50, 0, fk, dk, gp, ov);
        vecs++;
        if (wa.size() != 2) begin
            errs++;
            $display("FAIL clip_count got %0d want 2", wa.size());
        end else begin
            vecs++;
            if (wa[0] != 19198 || wa[1] != 19199) begin
                errs++;
                $display("FAIL clip_addr got %0d,%0d want 19198,19199",
                         wa[0], wa[1]);
            end
        end
        vecs++;
        if (dk != 4) begin
            errs++;
            $display("FAIL clip_done got %0d want 4", dk);
        end
        ack();
    endtask

    task automatic test_degenerate();
        int cx[3] = '{10, 160, 10};
        int cw[3] = '{0, 3, 3};
        int ch[3] = '{2, 2, 0};
        int fk, dk;
        bit gp, ov;
        for (int i = 0; i < 3; i++) begin
            issue(cx[i], 5, cw[i], ch[i], 6);
            collect(20, 0, fk, dk, gp, ov);
            vecs++;
            if (wa.size() != 0 || dk != 2) begin
                errs++;
                $display("FAIL degen%0d got writes=%0d k=%0d want 0/2",
                         i, wa.size(), dk);
            end
            ack();
            vecs++;
            if (bus.busy !== 1'b0) begin
                errs++;
                $display("FAIL degen%0d_ack got busy=%b want 0",
                         i, bus.busy);
            end
        end
    endtask

    task automatic test_full_screen();
        int fk, dk, bad;
        bit gp, ov;
        issue(0, 0, 160, 120, 7);
        collect(20000, 0, fk, dk, gp, ov);
        vecs++;
        if (wa.size() != 19200 || dk != 19202 || gp) begin
            errs++;
            $display("FAIL full_count got n=%0d k=%0d gap=%b want 19200/19202/0",
                     wa.size(), dk, gp);
        end
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != 7) bad++;
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL full_addr got %0d bad words want 0", bad);
        end
        ack();
    endtask

    task automatic test_cmd_change();
        int exp_a[6] = '{810, 811, 812, 970, 971, 972};
        int fk, dk, bad;
        bit gp, ov;
        issue(10, 5, 3, 2, 5);
        collect(50, 2, fk, dk, gp, ov);
        bus.in_cont_signal = 1'b0;
        bad = (wa.size() != 6) ? 1 : 0;
        for (int i = 0; i < wa.size() && i < 6; i++)
            if (wa[i] != exp_a[i] || wd[i] != 5) bad++;
        vecs++;
        if (bad != 0 || dk != 8) begin
            errs++;
            $display("FAIL cmdchg got n=%0d bad=%0d k=%0d want 6/0/8",
                     wa.size(), bad, dk);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int n, bad, fk, dk;
        bit gp, ov;
        issue(10, 5, 3, 2, 5);
        n = 0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            step();
            if (bus.wr_en) n++;
        end
        vecs++;
        if (n != 3) begin
            errs++;
            $display("FAIL rmid_prewrites got %0d want 3", n);
        end
        Reset = 1'b0;
        step();
        vecs++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL rmid_cut got wr_en=%b busy=%b want 0/0",
                     bus.wr_en, bus.busy);
        end
        Reset = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (bus.out_cont_signal || bus.wr_en || bus.busy) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL rmid_quiet got %0d active cycles want 0", bad);
        end
        issue(10, 5, 3, 2, 5);
        vecs++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL rmid_reaccept got busy=%b want 1", bus.busy);
        end
        collect(50, 0, fk, dk, gp, ov);
        vecs++;
        if (wa.size() != 6 || dk != 8) begin
            errs++;
            $display("FAIL rmid_refill got n=%0d k=%0d want 6/8",
                     wa.size(), dk);
        end else begin
            vecs++;
            if (wa[0] != 810 || wa[5] != 972) begin
                errs++;
                $display("FAIL rmid_refill_addr got %0d..%0d want 810..972",
                         wa[0], wa[5]);
            end
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int fk, dk;
        bit gp, ov;
        issue(10, 5, 3, 2, 5);
        collect(50, 0, fk, dk, gp, ov);
        set_cmd(20, 0, 2, 1, 6);
        bus.in_cont_signal = 1'b1;
        bus.next_fin_signal = 1'b1;
        step();
        bus.next_fin_signal = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.out_cont_signal !== 1'b0) begin
            errs++;
            $display("FAIL b2b_same_cycle got busy=%b oc=%b want 0/0",
                     bus.busy, bus.out_cont_signal);
        end
        step();
        bus.in_cont_signal = 1'b0;
        vecs++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_next_cycle got busy=%b want 1", bus.busy);
        end
        collect(50, 0, fk, dk, gp, ov);
        vecs++;
        if (wa.size() != 2) begin
            errs++;
            $display("FAIL b2b_count got %0d want 2", wa.size());
        end else begin
            vecs++;
            if (wa[0] != 20 || wa[1] != 21 || wd[0] != 6 || wd[1] != 6) begin
                errs++;
                $display("FAIL b2b_wr got %0d/%0d,%0d/%0d want 20/6,21/6",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
        ack();
    endtask

    initial begin
        Reset               = 1'b0;
        bus.in_cont_signal  = 1'b0;
        bus.next_fin_signal = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        test_reset();
        test_basic_fill();
        test_clipping();
        test_degenerate();
        test_full_screen();
        test_cmd_change();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/frame_fill_writer.md
Name: frame_fill_writer

Overview:
- Writer side of the frame-memory path. The screen flasher reads framebuffer words at offset x + y*SCR_WIDTH and plots them to the VGA adapter; this block writes those words.
- Takes one rectangle-fill command (origin, size, colour) and clips it to the screen. It then writes the colour into every covered framebuffer word, one word per clock, in raster order.
- Uses the same continuation handshake as the flasher (in_cont_signal / out_cont_signal / next_fin_signal), so writer and flasher can be chained.

Parameters:
- SCR_WIDTH, 160, pixels per row.
- SCR_HEIGHT, 120, rows.
- X_BITS, 8, width of x coordinate and cmd_w.
- Y_BITS, 7, width of y coordinate and cmd_h.
- ADDR_SIZE, 15, framebuffer address width (must cover SCR_WIDTH*SCR_HEIGHT-1 = 19199).
- COLOR_SIZE, 3, bits per framebuffer word.

Ports:
- Clck  in  1  system clock, rising edge.
- Reset  in  1  reset; synchronous, active-low.
- in_cont_signal  in  1  start request; accepted only in IDLE with out_cont_signal==0.
- cmd_x  in  X_BITS  rectangle left column; sampled at accept.
- cmd_y  in  Y_BITS  rectangle top row; sampled at accept.
- cmd_w  in  X_BITS  rectangle width in pixels; sampled at accept.
- cmd_h  in  Y_BITS  rectangle height in rows; sampled at accept.
- cmd_color  in  COLOR_SIZE  fill colour; sampled at accept.
- wr_en  out  1  framebuffer write strobe, registered.
- wr_addr  out  ADDR_SIZE  write address = x + y*SCR_WIDTH, registered.
- wr_data  out  COLOR_SIZE  write data = latched colour, registered.
- busy  out  1  high from accept until DONE is left.
- out_cont_signal  out  1  fill finished; held until acknowledged.
- next_fin_signal  in  1  acknowledge from the next stage; clears out_cont_signal.

Behaviour:
- Reset (Reset==0 at a clock edge), from any state including mid-fill:
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, out_cont_signal=0.
  - No write is issued in the cycle after a reset edge.
- States are IDLE, LOAD, WRITE, DONE.
- IDLE:
  - If in_cont_signal==1 and out_cont_signal==0: latch all cmd_* inputs, set busy=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly one cycle):
  - Compute x_end = min(cmd_x+cmd_w, SCR_WIDTH) and y_end = min(cmd_y+cmd_h, SCR_HEIGHT). Sums use X_BITS+1 and Y_BITS+1 bits, so there is no wraparound.
  - Degenerate command (cmd_w==0, cmd_h==0, cmd_x>=SCR_WIDTH or cmd_y>=SCR_HEIGHT): go to DONE; zero writes are issued.
  - Otherwise set the cursor to (cmd_x, cmd_y) and go to WRITE.
- WRITE:
  - Each cycle: wr_en=1, wr_addr=cursor offset, wr_data=latched colour.
  - Cursor advances x+1; when x+1==x_end it sets x=cmd_x and y+1.
  - After the write at (x_end-1, y_end-1): go to DONE, wr_en=0 on that edge.
  - Writes are gapless: exactly (x_end-cmd_x)*(y_end-cmd_y) consecutive wr_en cycles.
- DONE:
  - out_cont_signal=1, busy stays 1, wr_en=0.
  - When next_fin_signal==1 is sampled: out_cont_signal=0, busy=0, go to IDLE.
  - A request with in_cont_signal high in that same cycle is not accepted. It is accepted on the next cycle if still high.
- Latency:
  - First wr_en is high two edges after the accept edge (accept → LOAD → WRITE).
  - out_cont_signal rises on the edge that drops wr_en after the last write.
  - Degenerate command: out_cont_signal rises two edges after accept.
- Ignored inputs:
  - in_cont_signal and cmd_* changes while busy.
  - next_fin_signal outside DONE.
- Address arithmetic:
  - y*SCR_WIDTH is a constant multiply, sized to ADDR_SIZE.
  - The maximum address produced is SCR_WIDTH*SCR_HEIGHT-1.

Test Plan:
- Reset: hold Reset=0 for 2 cycles while in_cont_signal=1 → wr_en=0, wr_addr=0, busy=0, out_cont_signal=0; no accept.
- Fill x=10, y=5, w=3, h=2, colour=3'b101:
  - Exactly 6 consecutive writes: addresses 810, 811, 812, 970, 971, 972, all with data 5.
  - First write is 2 edges after accept.
  - out_cont_signal=1 stays high for 20 cycles until next_fin_signal is pulsed, then drops and busy=0.
- Clipping: x=158, y=119, w=5, h=4 → exactly 2 writes, addresses 19198 and 19199, then DONE.
- Degenerate: w=0 → zero writes, out_cont_signal=1 two edges after accept. Repeat with x=160, then with h=0 → same result.
- Full screen: x=0, y=0, w=160, h=120, colour=7 → 19200 gapless writes from address 0 to 19199, no duplicates.
- Mid-operation events, using the x=10, y=5, w=3, h=2 fill:
  - Changing cmd_* after the 2nd write changes nothing.
  - Pulsing Reset=0 after the 3rd write → wr_en=0 from the next edge, out_cont_signal never rises, busy=0.
  - A new request is accepted afterwards.
